// File: rtl/pmp_pkg.sv
// ============================================================================
// Module   : pmp_pkg
// Purpose  : Shared PMP table item type, flag bit indices and widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmp_pkg;

    localparam int RISCV_ARCH       = 32;
    // Table entries are held at the widest supported address width;
    // bits above ABITS are always zero and are trimmed in synthesis.
    localparam int PMP_MAX_ABITS    = 64;

    localparam int CFG_PMP_FL_TOTAL = 5;
    localparam int PMP_FL_X         = 0;
    localparam int PMP_FL_W         = 1;
    localparam int PMP_FL_R         = 2;
    localparam int PMP_FL_L         = 3;
    localparam int PMP_FL_V         = 4;

    typedef struct packed {
        logic [PMP_MAX_ABITS-1:0]    start_addr;
        logic [PMP_MAX_ABITS-1:0]    end_addr;
        logic [CFG_PMP_FL_TOTAL-1:0] flags;
    } PmpTableItemType;

endpackage

`default_nettype wire

// File: rtl/pmp_match.sv
// ============================================================================
// Module   : pmp_match
// Purpose  : Combinational lowest-index priority matcher for one lookup port.
//            Locked-region behaviour is compiled in with PMP_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_match
    import pmp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ABITS   = RISCV_ARCH
) (
    input  PmpTableItemType   i_table [ENTRIES],
    input  logic [ABITS-1:0]  i_addr,
    input  logic [2:0]        i_acc,
    input  logic              i_mmode,
    output logic              o_ok
);

    logic [PMP_MAX_ABITS-1:0] w_addr;
    logic                     w_hit;
    logic [2:0]               w_hit_perm;
    logic                     w_hit_lock;
    logic                     w_perm;

    assign w_addr = PMP_MAX_ABITS'(i_addr);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_perm = 3'b000;
        w_hit_lock = 1'b0;
        for (int n = ENTRIES - 1; n >= 0; n--) begin
            if (i_table[n].flags[PMP_FL_V] &&
                (i_table[n].start_addr <= w_addr) &&
                (w_addr <= i_table[n].end_addr)) begin
                w_hit      = 1'b1;
                w_hit_perm = i_table[n].flags[PMP_FL_R:PMP_FL_X];
                w_hit_lock = i_table[n].flags[PMP_FL_L];
            end
        end
    end

    assign w_perm = |(i_acc & w_hit_perm);

`ifdef PMP_LOCK_EN
    always_comb begin
        o_ok = 1'b0;
        if (!$onehot(i_acc))
            o_ok = 1'b0;
        else if (!w_hit)
            o_ok = i_mmode;
        else if (w_perm)
            o_ok = 1'b1;
        else
            o_ok = i_mmode & ~w_hit_lock;
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = w_hit_lock;

    // Without locking, machine mode is never restricted by the table.
    always_comb begin
        o_ok = 1'b0;
        if (!$onehot(i_acc))
            o_ok = 1'b0;
        else if (i_mmode)
            o_ok = 1'b1;
        else
            o_ok = w_hit & w_perm;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/pmp_checker.sv
// ============================================================================
// Module   : pmp_checker
// Purpose  : Multi-port PMP region checker with 1-cycle registered responses
//            and first-fault capture. Define PMP_LOCK_EN for region locking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_checker
    import pmp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int NPORTS  = 2,
    parameter int ABITS   = RISCV_ARCH,
    localparam int IW     = $clog2(ENTRIES),
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic [IW-1:0]               i_wr_idx,
    input  logic [ABITS-1:0]            i_wr_start,
    input  logic [ABITS-1:0]            i_wr_end,
    input  logic [CFG_PMP_FL_TOTAL-1:0] i_wr_flags,
    input  logic [NPORTS-1:0]           i_req_valid,
    input  logic [NPORTS*ABITS-1:0]     i_req_addr,
    input  logic [NPORTS*3-1:0]         i_req_acc,
    input  logic [NPORTS-1:0]           i_req_mmode,
    output logic [NPORTS-1:0]           o_resp_valid,
    output logic [NPORTS-1:0]           o_resp_ok,
    output logic                        o_fault_valid,
    output logic [ABITS-1:0]            o_fault_addr,
    output logic [PW-1:0]               o_fault_port,
    input  logic                        i_fault_clr
);

    PmpTableItemType    r_table [ENTRIES];
    logic [NPORTS-1:0]  r_resp_valid;
    logic [NPORTS-1:0]  r_resp_ok;
    logic               r_fault_valid;
    logic [ABITS-1:0]   r_fault_addr;
    logic [PW-1:0]      r_fault_port;

    logic [NPORTS-1:0]  w_ok;
    logic               w_wr_allow;
    logic               w_deny_any;
    logic [PW-1:0]      w_deny_port;
    logic [ABITS-1:0]   w_deny_addr;

`ifdef PMP_LOCK_EN
    assign w_wr_allow = ~r_table[i_wr_idx].flags[PMP_FL_L];
`else
    assign w_wr_allow = 1'b1;
`endif

    // Lookups read r_table directly, so a same-cycle write is not visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < ENTRIES; n++)
                r_table[n] <= '0;
        end else if (i_we && w_wr_allow) begin
            r_table[i_wr_idx].start_addr <= PMP_MAX_ABITS'(i_wr_start);
            r_table[i_wr_idx].end_addr   <= PMP_MAX_ABITS'(i_wr_end);
            r_table[i_wr_idx].flags      <= i_wr_flags;
        end
    end

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            pmp_match #(
                .ENTRIES (ENTRIES),
                .ABITS   (ABITS)
            ) u_match (
                .i_table (r_table),
                .i_addr  (i_req_addr[p*ABITS +: ABITS]),
                .i_acc   (i_req_acc[p*3 +: 3]),
                .i_mmode (i_req_mmode[p]),
                .o_ok    (w_ok[p])
            );
        end
    endgenerate

    always_comb begin
        w_deny_any  = 1'b0;
        w_deny_port = '0;
        w_deny_addr = '0;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (i_req_valid[p] && !w_ok[p]) begin
                w_deny_any  = 1'b1;
                w_deny_port = PW'(p);
                w_deny_addr = i_req_addr[p*ABITS +: ABITS];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_valid  <= '0;
            r_resp_ok     <= '0;
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_port  <= '0;
        end else begin
            r_resp_valid <= i_req_valid;
            r_resp_ok    <= w_ok & i_req_valid;
            // A clear in the same cycle as a new denial re-arms capture.
            if (w_deny_any && (!r_fault_valid || i_fault_clr)) begin
                r_fault_valid <= 1'b1;
                r_fault_addr  <= w_deny_addr;
                r_fault_port  <= w_deny_port;
            end else if (i_fault_clr) begin
                r_fault_valid <= 1'b0;
            end
        end
    end

    assign o_resp_valid  = r_resp_valid;
    assign o_resp_ok     = r_resp_ok;
    assign o_fault_valid = r_fault_valid;
    assign o_fault_addr  = r_fault_addr;
    assign o_fault_port  = r_fault_port;

endmodule

`default_nettype wire
